// File: rtl/counter_job_arbiter.sv
// counter_job_arbiter
//
// Arbitrates a shared 2-bit mode counter between two requesters. A job is a
// counter mode {s1,s0} plus a step count. Jobs are granted round-robin, then
// the counter advances once per cycle for the requested number of steps and
// a single-cycle done pulse marks completion.
//
// Ports
//   clock                  rising-edge clock
//   reset                  synchronous active-high reset
//   req_valid[1:0]         per-requester job request
//   req_mode0/1[1:0]       requested mode {s1,s0}
//   req_steps0/1[STEP_W-1:0] requested step count (0 allowed)
//   req_ready[1:0]         one-hot combinational accept strobe
//   s1, s0                 mode of the current / most recent job
//   step_en                count advances at the next edge
//   q1, q0                 live count value
//   busy                   job in RUN or DONE
//   done                   single-cycle completion pulse
//   done_id                owner of the completing job (valid with done)
module counter_job_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_mode0,
  input  logic [1:0]        req_mode1,
  input  logic [STEP_W-1:0] req_steps0,
  input  logic [STEP_W-1:0] req_steps1,
  output logic [1:0]        req_ready,
  output logic              s1,
  output logic              s0,
  output logic              step_en,
  output logic              q1,
  output logic              q0,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        mode_q;
  logic [STEP_W-1:0] rem_q;
  logic              owner_q;
  // Last requester granted; reset to 1 so requester 0 wins the first tie.
  logic              last_q;

  logic              grant_id;
  logic              grant_vld;
  logic              accept;
  logic [1:0]        sel_mode;
  logic [STEP_W-1:0] sel_steps;

  // Round-robin selection between the two requesters.
  always_comb begin
    grant_id  = 1'b0;
    grant_vld = 1'b0;
    unique case (req_valid)
      2'b01: begin grant_id = 1'b0;    grant_vld = 1'b1; end
      2'b10: begin grant_id = 1'b1;    grant_vld = 1'b1; end
      2'b11: begin grant_id = ~last_q; grant_vld = 1'b1; end
      default: begin grant_id = 1'b0;  grant_vld = 1'b0; end
    endcase
  end

  // Ready is gated by reset so nothing is taken on a reset edge.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && grant_vld && !reset) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign accept    = |req_ready;
  assign sel_mode  = grant_id ? req_mode1  : req_mode0;
  assign sel_steps = grant_id ? req_steps1 : req_steps0;

  // Count update for the latched mode.
  always_comb begin
    count_d = count_q;
    unique case (mode_q)
      2'd0: count_d = count_q + 2'd1;
      2'd1: count_d = count_q - 2'd1;
      2'd2: count_d = (count_q == 2'd2) ? 2'd0 : count_q + 2'd1;
      2'd3: count_d = (count_q == 2'd0) ? 2'd2 : count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (sel_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        step_en = 1'b1;
        busy    = 1'b1;
        if (rem_q == STEP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      mode_q  <= 2'd0;
      rem_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= sel_mode;
        rem_q   <= sel_steps;
        owner_q <= grant_id;
        last_q  <= grant_id;
      end
      if (step_en) begin
        count_q <= count_d;
        rem_q   <= rem_q - STEP_W'(1);
      end
    end
  end

  assign s1      = mode_q[1];
  assign s0      = mode_q[0];
  assign q1      = count_q[1];
  assign q0      = count_q[0];
  assign done_id = owner_q;

endmodule

// File: doc/counter_job_arbiter.md
# counter_job_arbiter

Arbitrates a shared 2-bit mode counter between two requesters. Each requester submits a job: a counter mode plus a step count. The block grants jobs round-robin, then advances the counter once per cycle for the requested number of steps. It pulses done when the job finishes. It drives the mode-select lines and keeps the authoritative count, so downstream logic sees {s1,s0}, a step strobe and the live count value.

## Interface
- STEP_W, 4: width of each requester's step-count field; a job may request 0 to 2^STEP_W-1 steps.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- req_valid  in  2  per-requester job request; bit i belongs to requester i.
- req_mode0, req_mode1  in  2 each  requested mode {s1,s0} for requester 0 and 1.
- req_steps0, req_steps1  in  STEP_W each  requested step count.
- req_ready  out  2  one-hot accept strobe; bit i high means requester i's job is taken this cycle.
- s1, s0  out  1 each  mode of the current or most recent job.
- step_en  out  1  high in every cycle in which the count advances at the next edge.
- q1, q0  out  1 each  current count, bits [1] and [0].
- busy  out  1  high while a job is in RUN or DONE.
- done  out  1  single-cycle pulse marking job completion.
- done_id  out  1  requester whose job completed; valid while done is high.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If exactly one req_valid bit is set, that requester is granted.
  - If both bits are set, grant the requester that was not granted last.
  - The grant pointer updates on every accept.
- Accept:
  - req_ready[g] = (state==IDLE) && req_valid[g] && !reset. It is combinational.
  - On accept, latch the mode into {s1,s0}, latch steps into remaining, and record g as the owner.
  - Requesters hold valid, mode and steps stable until ready.
  - Payload presented while not ready is ignored.
- After accept, the next state is RUN if steps != 0, otherwise DONE (a zero-step job never asserts step_en).
- RUN:
  - step_en=1 every cycle.
  - At each edge the count updates per mode and remaining decrements.
  - When remaining==1, the next state is DONE.
- DONE: done=1 and done_id=owner for one cycle, then IDLE.
- Count update per mode {s1,s0}:
  - 0: count+1, mod 4.
  - 1: count-1, mod 4 (0 goes to 3).
  - 2: if count==2 then 0, else count+1 (3 goes to 0).
  - 3: if count==0 then 2, else count-1 (3 goes to 2).
- The count persists across jobs and changes only when step_en is high.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, count 0, {s1,s0}=00, remaining 0.
  - step_en 0, done 0, done_id 0, busy 0, req_ready 0.
  - The grant pointer favours requester 0 at the first contention.
- Accept in cycle T with N>0 steps:
  - step_en is high in cycles T+1 through T+N.
  - q reflects the k-th step after the edge ending cycle T+k.
  - done is high in cycle T+N+1.
  - The earliest next accept is T+N+2.
- Accept in cycle T with N=0: done is high in cycle T+1.
- Throughput is one job per N+2 cycles.
- Reset asserted mid-RUN or mid-DONE:
  - The job aborts at that edge with no done pulse.
  - Count and all outputs return to reset values.
- New requests arriving during RUN or DONE are held off (ready=0) and are not queued.
- {s1,s0} changes only on accept.

## Test plan
- Reset, then requester 0 submits mode 0 with steps=5. Required: step_en for 5 cycles; q goes 1,2,3,0,1; done with done_id=0 one cycle after the last step; busy drops the cycle after done.
- From count 1, submit mode 3 with steps=4. Required: q goes 0,2,1,0. Then submit mode 2 with steps=3. Required: q goes 1,2,0.
- Both requesters valid continuously, each with steps=1. Required: grants alternate 0,1,0,1 starting with 0; the accept interval is 3 cycles; exactly one req_ready bit is ever high.
- Requester 1 submits steps=0. Required: no step_en; q unchanged; done with done_id=1 in the cycle after accept.
- Assert reset during the 3rd step of a 10-step mode 1 job. Required: no done; q=0 and busy=0 after the edge; a new job is accepted in the first cycle after reset deasserts.
- From count 3, run mode 2 for 1 step. Required: q=0. From count 3, run mode 1 for 4 steps. Required: q goes 2,1,0,3 (wrap-around).
